hazard_detect: RTL

Decode-stage RAW hazard detector for the 5-stage pipeline, no forwarding path. It compares the decode instruction's source registers against the destinations of the two most recently issued instructions. It produces the 2-bit `stall_count` consumed by the PC stall controller, plus the decode `id_issue` strobe. The register file bypasses write-to-read in the same cycle, so a value written in WB is readable by the instruction in ID that cycle.

---
 rtl/hazard_detect_pkg.sv | 33 +++
 rtl/dff.sv | 29 ++
 rtl/hist_entry.sv | 36 +++
 rtl/hazard_detect.sv | 84 ++++++++
 4 files changed

// File: rtl/hazard_detect_pkg.sv
// +-----------------------------------------------------------------------+
// | hazard_detect_pkg                                                       |
// | Shared pipeline types: register width, issue-history entry, RAW need.   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

package hazard_detect_pkg;

  localparam int REG_W = 3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } hist_t;

  // Bubbles a source still needs: 2 if its producer is in EX, 1 if in MEM.
  function automatic logic [1:0] src_need(input logic             en,
                                          input logic [REG_W-1:0] src,
                                          input hist_t            h1,
                                          input hist_t            h2);
    logic [1:0] need;
    need = 2'd0;
    if (en) begin
      if (h1.valid && (h1.rd == src))      need = 2'd2;
      else if (h2.valid && (h2.rd == src)) need = 2'd1;
    end
    return need;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff.sv
// +-----------------------------------------------------------------------+
// | dff                                                                     |
// | Enabled D flip-flop bank with synchronous active-high reset to zero.    |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)     r_q <= '0;
    else if (en) r_q <= d;
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/hist_entry.sv
// +-----------------------------------------------------------------------+
// | hist_entry                                                              |
// | One issue-history slot {valid, rd} with load enable and clear.          |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

module hist_entry
  import hazard_detect_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  clr,
  input  hist_t d,
  output hist_t q
);

  hist_t w_d;
  logic  w_en;

  // Clear overrides a held slot so a flush always empties the history.
  assign w_d  = clr ? '0 : d;
  assign w_en = en | clr;

  dff #(.W($bits(hist_t))) u_dff (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .d   (w_d),
    .q   (q)
  );

endmodule

`default_nettype wire

// File: rtl/hazard_detect.sv
// +-----------------------------------------------------------------------+
// | hazard_detect                                                           |
// | Decode-stage RAW hazard detector (no forwarding): stall count, issue.   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int REG_W = hazard_detect_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_rs_en,
  input  logic             id_rt_en,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_rd,
  output logic [1:0]       stall_count,
  output logic             id_issue,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  hist_t            w_h1;
  hist_t            w_h2;
  hist_t            w_h1_next;
  logic [1:0]       w_need_rs;
  logic [1:0]       w_need_rt;
  logic [1:0]       w_need_max;
  logic             w_active;
  logic [CNT_W-1:0] r_stall_cycles;

  assign w_need_rs  = src_need(id_rs_en, id_rs, w_h1, w_h2);
  assign w_need_rt  = src_need(id_rt_en, id_rt, w_h1, w_h2);
  assign w_need_max = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;

  assign w_active    = id_valid & ~hold & ~flush;
  assign stall_count = w_active ? w_need_max : 2'b00;
  assign id_issue    = w_active & (stall_count == 2'b00);

  // A stalled or non-writing ID shifts a bubble into the EX slot.
  assign w_h1_next.valid = id_issue & id_wr_en;
  assign w_h1_next.rd    = id_rd;

  hist_entry u_h1 (
    .clk (clk),
    .rst (rst),
    .en  (~hold),
    .clr (flush),
    .d   (w_h1_next),
    .q   (w_h1)
  );

  hist_entry u_h2 (
    .clk (clk),
    .rst (rst),
    .en  (~hold),
    .clr (flush),
    .d   (w_h1),
    .q   (w_h2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (id_valid && (stall_count != 2'b00) &&
                 (r_stall_cycles != c_cnt_max)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
